// File: rtl/sd_block_dma.sv
// Sector DMA sequencer for the sdcard block cache.
// Moves one 512-byte sector between the card cache and main memory using the cache's register bus.
module sd_block_dma #(
  parameter int          ADDR_SHIFT = 9,
  parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        dir_i,
  input  logic [31:0] lba_i,
  input  logic [31:0] mem_base_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] sd_a_o,
  output logic [31:0] sd_d_o,
  output logic        sd_we_o,
  input  logic [31:0] sd_spo_i,
  output logic [31:0] mem_a_o,
  output logic [31:0] mem_d_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_spo_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_POLL0, S_SETADDR, S_FILL, S_TRIG,
    S_SETTLE, S_POLL1, S_DRAIN, S_DONE, S_FAIL
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [23:0] tmo_q, tmo_d;
  logic [31:0] lba_q, lba_d;
  logic [31:0] base_q, base_d;
  logic        dir_q, dir_d;
  logic        err_q, err_d;

  logic [63:0] cardAddr;
  logic        addrOverflow;
  logic        pollExpired;
  logic [31:0] wordOffset;
  logic [15:0] cacheAddr;

  // Shifting in 64 bits lets the overflow test see every bit lost by the 32-bit truncation.
  assign cardAddr     = {32'b0, lba_q} << ADDR_SHIFT;
  assign addrOverflow = |cardAddr[63:32];
  assign pollExpired  = (tmo_q == TIMEOUT - 24'd1);
  assign wordOffset   = {23'b0, cnt_q, 2'b00};
  assign cacheAddr    = {7'b0, cnt_q, 2'b00};
  assign err_o        = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lba_q   <= '0;
      base_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      lba_q   <= lba_d;
      base_q  <= base_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    lba_d    = lba_q;
    base_d   = base_q;
    dir_d    = dir_q;
    err_d    = err_q;
    busy_o   = (state_q != S_IDLE);
    done_o   = 1'b0;
    sd_a_o   = 16'h2010;
    sd_d_o   = '0;
    sd_we_o  = 1'b0;
    mem_a_o  = '0;
    mem_d_o  = '0;
    mem_we_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lba_d   = lba_i;
          base_d  = mem_base_i & 32'hFFFF_FFFC;
          dir_d   = dir_i;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        sd_a_o = 16'h2000;
        if (sd_spo_i[0] || addrOverflow) begin
          state_d = S_FAIL;
        end else begin
          tmo_d   = '0;
          state_d = S_POLL0;
        end
      end
      S_POLL0, S_POLL1: begin
        // Ready wins over the timeout when both happen in the same cycle.
        if (sd_spo_i[0]) begin
          if (state_q == S_POLL0) state_d = S_SETADDR;
          else                    state_d = dir_q ? S_DONE : S_DRAIN;
        end else if (pollExpired) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_SETADDR: begin
        sd_a_o  = 16'h1000;
        sd_d_o  = cardAddr[31:0];
        sd_we_o = 1'b1;
        cnt_d   = '0;
        state_d = dir_q ? S_FILL : S_TRIG;
      end
      S_FILL: begin
        mem_a_o = base_q + wordOffset;
        sd_a_o  = cacheAddr;
        sd_d_o  = mem_spo_i;
        sd_we_o = 1'b1;
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == 7'd127) state_d = S_TRIG;
      end
      S_TRIG: begin
        sd_a_o  = dir_q ? 16'h1008 : 16'h1004;
        sd_d_o  = 32'd1;
        sd_we_o = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        tmo_d   = '0;
        state_d = S_POLL1;
      end
      S_DRAIN: begin
        sd_a_o   = cacheAddr;
        mem_a_o  = base_q + wordOffset;
        mem_d_o  = sd_spo_i;
        mem_we_o = 1'b1;
        cnt_d    = cnt_q + 7'd1;
        if (cnt_q == 7'd127) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_block_dma.sv
// Bench for sd_block_dma: behavioural sdcard cache and memory, a table of sector
// operations plus random ones, each checked against expectations built from the transfer rules.
module tb_sd_block_dma;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, dir;
  logic [31:0] lba, memBase;
  logic        busy, done, err;
  logic [15:0] sdA;
  logic [31:0] sdD, sdSpo;
  logic        sdWe;
  logic [31:0] memA, memD, memSpo;
  logic        memWe;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          dir;
    logic [31:0] lba;
    logic [31:0] base;
    logic [31:0] seed;
    bit          ncd;
    bit          stuck;
    int          busyCyc;
    bit          expErr;
  } opT;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wrT;

  sd_block_dma #(.ADDR_SHIFT(9), .TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .start_i(start), .dir_i(dir), .lba_i(lba),
    .mem_base_i(memBase), .busy_o(busy), .done_o(done), .err_o(err),
    .sd_a_o(sdA), .sd_d_o(sdD), .sd_we_o(sdWe), .sd_spo_i(sdSpo),
    .mem_a_o(memA), .mem_d_o(memD), .mem_we_o(memWe), .mem_spo_i(memSpo)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cardWord(logic [31:0] addr, int i);
    return addr * 32'h9E3779B1 + 32'(i) * 32'h01000193 + 32'h5A5A0000;
  endfunction

  // Card side: ready drops after a trigger and returns busyCycles cycles later; a read trigger then refills the cache.
  logic        cardReady = 1'b1;
  logic        cardNcd = 1'b0;
  logic        cardStuck = 1'b0;
  logic        cardIsRead = 1'b0;
  int          cardBusy = 0;
  int          busyCycles = 1;
  logic [31:0] cardAddr = '0;
  logic [31:0] cache [128];

  always_comb begin
    sdSpo = 32'hDEAD_BEEF;
    if (sdA == 16'h2000)      sdSpo = {31'b0, cardNcd};
    else if (sdA == 16'h2010) sdSpo = {31'b0, cardReady & ~cardStuck};
    else if (sdA < 16'h0200)  sdSpo = cache[sdA[8:2]];
  end

  always @(posedge clk) begin
    if (sdWe) begin
      if (sdA == 16'h1000) begin
        cardAddr <= sdD;
      end else if ((sdA == 16'h1004 || sdA == 16'h1008) && sdD == 32'd1) begin
        cardReady  <= 1'b0;
        cardBusy   <= busyCycles;
        cardIsRead <= (sdA == 16'h1004);
      end else if (sdA < 16'h0200) begin
        cache[sdA[8:2]] <= sdD;
      end
    end else if (!cardReady) begin
      if (cardBusy <= 1) begin
        cardReady <= 1'b1;
        if (cardIsRead) for (int i = 0; i < 128; i++) cache[i] <= cardWord(cardAddr, i);
      end else begin
        cardBusy <= cardBusy - 1;
      end
    end
  end

  // 4 KB memory window; word k of the window holds memFillSeed + k after a fill request.
  logic [31:0] memArr [1024];
  logic        memFillReq = 1'b0;
  logic [31:0] memFillSeed = '0;

  assign memSpo = memArr[memA[11:2]];

  always @(posedge clk) begin
    if (memFillReq) begin
      for (int k = 0; k < 1024; k++) memArr[k] <= memFillSeed + 32'(k);
    end else if (memWe) begin
      memArr[memA[11:2]] <= memD;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ctrl/sd_a"}, {43'b0, busy, done, err, sdWe, memWe, sdA}, {48'b0, 16'h2010});
    checkOutput({tag, " sd_d/mem_a"}, {sdD, memA}, 64'd0);
    checkOutput({tag, " mem_d"}, {32'b0, memD}, 64'd0);
  endtask

  task automatic applyStimulus(input string tag, input opT op, input bit midPulse);
    wrT          expSd[$], expMem[$], gotSd[$], gotMem[$];
    wrT          w;
    logic [31:0] baseAl, cardA;
    logic [63:0] wide;
    bit          expDone, seenPoll, firstWr, pollFirst, pulsed, finished;
    int          expEnd, cyc, busyCnt, doneCnt, doneCyc, errCyc, endCyc, mism;

    // Expected transaction lists and end cycle (cycle 1 = first cycle after the accepted start).
    baseAl  = op.base & 32'hFFFF_FFFC;
    wide    = {32'b0, op.lba} * 64'd512;
    cardA   = wide[31:0];
    expDone = 1'b0;
    if (op.ncd || wide[63:32] != 0) begin
      expEnd = 1 + 1 + 1;
    end else if (op.stuck) begin
      expEnd = 1 + TMO + 1 + 1;
    end else begin
      w = '{32'h1000, cardA};
      expSd.push_back(w);
      if (op.dir) for (int i = 0; i < 128; i++) begin
        w.a = 32'(4 * i);
        w.d = op.seed + (((baseAl + 32'(4 * i)) >> 2) & 32'h3FF);
        expSd.push_back(w);
      end
      w = '{op.dir ? 32'h1008 : 32'h1004, 32'd1};
      expSd.push_back(w);
      if (op.busyCyc >= TMO) begin
        expEnd = 3 + (op.dir ? 128 : 0) + 2 + TMO + 1 + 1;
      end else begin
        expDone = 1'b1;
        expEnd  = 3 + (op.dir ? 128 : 0) + 2 + op.busyCyc + (op.dir ? 0 : 128) + 1;
        if (!op.dir) for (int i = 0; i < 128; i++) begin
          w.a = baseAl + 32'(4 * i);
          w.d = cardWord(cardA, i);
          expMem.push_back(w);
        end
      end
    end

    cardNcd    = op.ncd;
    cardStuck  = op.stuck;
    busyCycles = op.busyCyc;
    if (op.dir) begin
      memFillSeed = op.seed;
      memFillReq  = 1'b1;
      @(negedge clk);
      memFillReq  = 1'b0;
    end
    start = 1'b1; dir = op.dir; lba = op.lba; memBase = op.base;
    cyc = 0; busyCnt = 0; doneCnt = 0; doneCyc = 0; errCyc = 0;
    seenPoll = 0; firstWr = 0; pollFirst = 0; pulsed = 0; finished = 0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        lba = $urandom; memBase = $urandom; dir = ~op.dir;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneCyc == 0) doneCyc = cyc;
      end
      if (err && errCyc == 0) errCyc = cyc;
      if (busy && !sdWe && sdA == 16'h2010) seenPoll = 1;
      if (sdWe) begin
        if (!firstWr) begin firstWr = 1; pollFirst = seenPoll; end
        w = '{{16'b0, sdA}, sdD};
        gotSd.push_back(w);
      end
      if (memWe) begin
        w = '{memA, memD};
        gotMem.push_back(w);
      end
      if (midPulse && !pulsed && gotMem.size() == 40) begin
        start = 1'b1; lba = $urandom; memBase = $urandom; dir = ~op.dir; pulsed = 1;
      end
      endCyc = (doneCyc != 0) ? doneCyc : errCyc;
      if ((endCyc != 0 && cyc >= endCyc + 2) || cyc >= 800) finished = 1;
    end

    checkOutput({tag, " end cycle"}, 64'(endCyc), 64'(expEnd));
    checkOutput({tag, " done pulses"}, 64'(doneCnt), 64'(expDone ? 1 : 0));
    checkOutput({tag, " err flag"}, {63'b0, err}, {63'b0, op.expErr});
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(expDone ? expEnd : expEnd - 1));
    checkOutput({tag, " sd write count"}, 64'(gotSd.size()), 64'(expSd.size()));
    mism = 0;
    for (int i = 0; i < gotSd.size() && i < expSd.size(); i++)
      if (gotSd[i] !== expSd[i]) mism++;
    checkOutput({tag, " sd write data errors"}, 64'(mism), 64'd0);
    checkOutput({tag, " mem write count"}, 64'(gotMem.size()), 64'(expMem.size()));
    mism = 0;
    for (int i = 0; i < gotMem.size() && i < expMem.size(); i++)
      if (gotMem[i] !== expMem[i]) mism++;
    checkOutput({tag, " mem write data errors"}, 64'(mism), 64'd0);
    if (expSd.size() > 0) checkOutput({tag, " ready polled before first write"}, {63'b0, pollFirst}, 64'd1);

    cardStuck = 1'b0;
    for (int k = 0; k < 400 && !cardReady; k++) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    opT table_ [11];
    opT op;
    int fillCnt;

    table_[0]  = '{1'b0, 32'd3,          32'h0000_4000, 32'h0,         1'b0, 1'b0, 50,  1'b0};
    table_[1]  = '{1'b1, 32'd1,          32'h0000_0000, 32'hA500_0000, 1'b0, 1'b0, 30,  1'b0};
    table_[2]  = '{1'b0, 32'd4,          32'h0000_1000, 32'h0,         1'b1, 1'b0, 10,  1'b1};
    table_[3]  = '{1'b0, 32'd6,          32'h0000_1000, 32'h0,         1'b0, 1'b1, 10,  1'b1};
    table_[4]  = '{1'b0, 32'd5,          32'h0000_0100, 32'h0,         1'b0, 1'b0, 1,   1'b0};
    table_[5]  = '{1'b0, 32'h0080_0000,  32'h0000_4000, 32'h0,         1'b0, 1'b0, 10,  1'b1};
    table_[6]  = '{1'b0, 32'h007F_FFFF,  32'h0000_0800, 32'h0,         1'b0, 1'b0, 10,  1'b0};
    table_[7]  = '{1'b1, 32'd9,          32'hFFFF_FF03, 32'h0000_1000, 1'b0, 1'b0, 5,   1'b0};
    table_[8]  = '{1'b0, 32'd7,          32'h0000_0200, 32'h0,         1'b0, 1'b0, 200, 1'b1};
    table_[9]  = '{1'b1, 32'd8,          32'h0000_0300, 32'h1234_0000, 1'b0, 1'b0, 200, 1'b1};
    table_[10] = '{1'b0, 32'd2,          32'hFFFF_FFF0, 32'h0,         1'b0, 1'b0, 3,   1'b0};

    rst = 1'b1; start = 1'b0; dir = 1'b0; lba = '0; memBase = '0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 11; t++) applyStimulus($sformatf("table%0d", t), table_[t], 1'b0);

    // A start pulse in the middle of DRAIN must not disturb the transfer in flight.
    op = '{1'b0, 32'd11, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 20, 1'b0};
    applyStimulus("startMidDrain", op, 1'b1);

    // Reset in the 60th FILL cycle, then a normal read.
    busyCycles = 20; cardNcd = 1'b0;
    memFillSeed = 32'h7700_0000; memFillReq = 1'b1;
    @(negedge clk);
    memFillReq = 1'b0;
    start = 1'b1; dir = 1'b1; lba = 32'd2; memBase = 32'h0000_0800;
    fillCnt = 0;
    for (int k = 0; k < 400 && fillCnt < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sdWe && sdA < 16'h0200) fillCnt++;
      if (fillCnt == 60) rst = 1'b1;
    end
    checkOutput("rstMidFill reached fill cycle 60", 64'(fillCnt), 64'd60);
    @(negedge clk);
    checkResetState("rstMidFill");
    rst = 1'b0;
    @(negedge clk);
    op = '{1'b0, 32'd9, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 12, 1'b0};
    applyStimulus("afterReset", op, 1'b0);

    for (int r = 0; r < 10; r++) begin
      op.dir     = 1'($urandom_range(0, 1));
      op.lba     = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0080_0000) : 32'($urandom_range(0, 32'h007F_FFFF));
      op.base    = $urandom;
      op.seed    = $urandom;
      op.ncd     = ($urandom_range(0, 9) == 0);
      op.stuck   = 1'b0;
      op.busyCyc = int'($urandom_range(1, 80));
      op.expErr  = op.ncd || (op.lba[31:23] != 0);
      applyStimulus($sformatf("random%0d", r), op, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
